// File: rtl/debounce_edge_bank.sv
// Multi-channel input conditioner: synchroniser, polarity, debounce,
// rise/fall edge pulses and a one-shot long-press pulse per channel.
module debounce_edge_bank #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 0,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic                any_event
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] p_q, p_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic                any_q, any_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE;
    end else begin
      sync_q[0] <= signal;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Polarity-corrected level is registered once after the synchroniser.
  assign p_d = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1]
                                 : sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          lvl_d, rs_d, fl_d;

    always_comb begin
      dcnt_d = dcnt_q;
      lvl_d  = level_q[i];
      rs_d   = 1'b0;
      fl_d   = 1'b0;
      if (p_q[i] == level_q[i]) begin
        dcnt_d = '0;
      end else if (dcnt_q == DMAX) begin
        lvl_d  = p_q[i];
        dcnt_d = '0;
        rs_d   = p_q[i];
        fl_d   = ~p_q[i];
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dcnt_q <= '0;
      else     dcnt_q <= dcnt_d;
    end

    assign level_d[i] = lvl_d;
    assign rise_d[i]  = rs_d;
    assign fall_d[i]  = fl_d;

    if (HOLD_CYCLES > 0) begin : g_hold
      localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          hd;

      // Saturating at HMAX makes the pulse a one-shot per press.
      always_comb begin
        hcnt_d = hcnt_q;
        hd     = 1'b0;
        if (!level_q[i]) begin
          hcnt_d = '0;
        end else if (hcnt_q != HMAX) begin
          hcnt_d = hcnt_q + HW'(1);
          hd     = (hcnt_q == HMAX - HW'(1));
        end
      end

      always_ff @(posedge clk) begin
        if (rst) hcnt_q <= '0;
        else     hcnt_q <= hcnt_d;
      end

      assign hold_d[i] = hd;
    end else begin : g_nohold
      assign hold_d[i] = 1'b0;
    end
  end

  assign any_d = |(rise_d | fall_d | hold_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      hold_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      p_q     <= p_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
      any_q   <= any_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign hold      = hold_q;
  assign any_event = any_q;

endmodule

// File: tb/tb_debounce_edge_bank.sv
// Directed bench: active-high bank with hold, and an active-low bank
// without hold exercised across a mid-operation reset.
module tb_debounce_edge_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sa, sb;
  logic [1:0] la, ra, fa, ha;
  logic [1:0] lb, rb, fb, hb;
  logic       ea, eb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debounce_edge_bank #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10), .ACTIVE_LOW(0)
  ) u_a (
    .clk(clk), .rst(rst), .signal(sa),
    .level(la), .rise(ra), .fall(fa), .hold(ha), .any_event(ea)
  );

  debounce_edge_bank #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(0), .ACTIVE_LOW(1)
  ) u_b (
    .clk(clk), .rst(rst), .signal(sb),
    .level(lb), .rise(rb), .fall(fb), .hold(hb), .any_event(eb)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sa  = 2'b00;
    sb  = 2'b11;
    step(3);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_a", {7'd0, la, ra, fa, ha, ea}, 16'h0);
      chk("idle_b", {7'd0, lb, rb, fb, hb, eb}, 16'h0);
    end

    // clean press and release on ch0
    sa = 2'b01;
    step(6);
    chk("press_early", {la, ra}, 4'b0000);
    step(1);
    chk("press_lvl", la, 2'b01);
    chk("press_rise", ra, 2'b01);
    chk("press_evt", ea, 1'b1);
    step(1);
    chk("rise_1cyc", ra, 2'b00);
    chk("evt_1cyc", ea, 1'b0);
    sa = 2'b00;
    step(6);
    chk("rel_early", {la, fa}, 4'b0100);
    step(1);
    chk("rel_lvl", la, 2'b00);
    chk("rel_fall", fa, 2'b01);
    chk("rel_evt", ea, 1'b1);
    chk("rel_norise", ra, 2'b00);
    step(1);
    chk("fall_1cyc", fa, 2'b00);
    step(4);

    // bounce: high 3, low 1, then steady high
    for (int j = 0; j < 12; j++) begin
      sa[0] = (j == 3) ? 1'b0 : 1'b1;
      step(1);
      chk("bounce_rise", {15'd0, ra[0]}, (j == 10) ? 16'd1 : 16'd0);
    end
    step(8);
    chk("hold0_early", ha, 2'b00);
    step(1);
    chk("hold0", ha, 2'b01);
    chk("hold0_evt", ea, 1'b1);
    sa = 2'b00;
    step(7);
    chk("bounce_fall", fa, 2'b01);
    step(3);

    // simultaneous press, hold on both
    sa = 2'b11;
    step(6);
    chk("sim_early", ra, 2'b00);
    step(1);
    chk("sim_rise", ra, 2'b11);
    step(9);
    chk("hold_early", ha, 2'b00);
    step(1);
    chk("hold_both", ha, 2'b11);
    chk("hold_evt", ea, 1'b1);
    step(1);
    chk("hold_1cyc", ha, 2'b00);
    step(18);
    chk("hold_once", ha, 2'b00);
    sa = 2'b00;
    step(7);
    chk("sim_fall", fa, 2'b11);
    chk("sim_lvl0", la, 2'b00);
    step(3);
    sa = 2'b10;
    step(7);
    chk("repress_rise", ra, 2'b10);
    step(10);
    chk("repress_hold", ha, 2'b10);
    sa = 2'b00;
    step(10);

    // ch1 chatter must not disturb ch0
    for (int j = 0; j < 8; j++) begin
      sa = {(j % 2 == 1), 1'b1};
      step(1);
      chk("indep_rise", ra, (j == 6) ? 2'b01 : 2'b00);
    end
    chk("indep_lvl", la, 2'b01);
    sa[1] = 1'b0;

    // active-low bank, reset while pressed
    sb = 2'b10;
    step(6);
    chk("al_early", rb, 2'b00);
    step(1);
    chk("al_rise", rb, 2'b01);
    chk("al_lvl", lb, 2'b01);
    chk("al_evt", eb, 1'b1);
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_lvl_b", lb, 2'b00);
    chk("rst_nofall_b", {fb, rb, 1'b0, eb}, 6'd0);
    chk("rst_lvl_a", la, 2'b00);
    step(1);
    chk("rst_nofall_b2", fb, 2'b00);
    rst = 1'b0;
    step(6);
    chk("rel_rst_early", {lb, rb}, 4'b0000);
    step(1);
    chk("rel_rst_rise_b", rb, 2'b01);
    chk("rel_rst_lvl_b", lb, 2'b01);
    chk("rel_rst_rise_a", ra, 2'b01);
    chk("al_nohold", hb, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
